// File: rtl/cache_fill_if.sv
// Signal bundle between the cache, main memory and the cache fill FSM.
// The slave modport is the FSM; the master modport is the cache/memory side.
interface cache_fill_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
);
  localparam int OW = $clog2(BLOCK_WORDS);

  // Handshake: no back-pressure anywhere. mem_en is a request that memory accepts in
  // the cycle it is high. memory_data_valid qualifies memory_data, and words return
  // in request order. write_data_array and write_tag_array are single-cycle write strobes.
  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  fsm_busy;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic [15:0]           memory_data;
  logic                  memory_data_valid;
  logic                  write_data_array;
  logic [OW-1:0]         word_offset;
  logic [15:0]           fill_data;
  logic                  write_tag_array;
  logic                  state_dbg;

  modport master (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, mem_en, memory_address, write_data_array, word_offset,
           fill_data, write_tag_array, state_dbg
  );

  modport slave (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, mem_en, memory_address, write_data_array, word_offset,
           fill_data, write_tag_array, state_dbg
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine. It issues one word read per cycle for the aligned block,
// writes the returned words into the data array in order, then writes the tag once.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input logic         clk,
  input logic         rst,
  cache_fill_if.slave bus
);
  localparam int OW = $clog2(BLOCK_WORDS);
  localparam int CW = OW + 1;
  localparam logic [CW-1:0]         FULL     = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0]         LAST     = CW'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(2 * BLOCK_WORDS - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]         recv_cnt_q, recv_cnt_d;

  assign bus.state_dbg = state_q;
  assign bus.fill_data = bus.memory_data;

  always_comb begin
    state_d              = state_q;
    base_d               = base_q;
    issue_cnt_d          = issue_cnt_q;
    recv_cnt_d           = recv_cnt_q;
    bus.fsm_busy         = 1'b0;
    bus.mem_en           = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.word_offset      = '0;
    bus.write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        bus.fsm_busy = bus.miss_detected;
        if (bus.miss_detected) begin
          base_d      = bus.miss_address & ~OFF_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        bus.fsm_busy    = 1'b1;
        bus.mem_en      = (issue_cnt_q < FULL);
        bus.word_offset = recv_cnt_q[OW-1:0];
        // Base offset bits are zero, so OR-ing the word offset never carries into the tag.
        if (bus.mem_en) begin
          bus.memory_address = base_q | ADDR_WIDTH'({issue_cnt_q[OW-1:0], 1'b0});
          issue_cnt_d        = issue_cnt_q + 1'b1;
        end
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          recv_cnt_d           = recv_cnt_q + 1'b1;
          if (recv_cnt_q == LAST) begin
            bus.write_tag_array = 1'b1;
            state_d             = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a latency-configurable memory model plus a scoreboard
// that checks every request, data-array write and tag write against expected queues.
module tb_cache_fill_fsm;
  logic clk;
  logic rst;

  cache_fill_if #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) bus ();

  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 0;
  int          lat      = 0;
  logic        inj_valid;
  logic [15:0] inj_data;

  logic [15:0] exp_addr_q[$];
  logic [18:0] exp_wr_q[$];
  logic [2:0]  exp_tag_q[$];

  // memory model: fixed latency, returns address ^ 16'h5A5A
  logic        v_pipe[8];
  logic [15:0] d_pipe[8];
  logic        resp_v;
  logic [15:0] resp_d;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        v_pipe[i] <= 1'b0;
        d_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0] <= bus.mem_en;
      d_pipe[0] <= bus.memory_address ^ 16'h5A5A;
      for (int i = 1; i < 8; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  always_comb begin
    resp_v = 1'b0;
    resp_d = '0;
    if (lat == 0) begin
      resp_v = bus.mem_en;
      resp_d = bus.memory_address ^ 16'h5A5A;
    end else begin
      resp_v = v_pipe[3'(lat - 1)];
      resp_d = d_pipe[3'(lat - 1)];
    end
    bus.memory_data_valid = resp_v | inj_valid;
    bus.memory_data       = resp_v ? resp_d : inj_data;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_en) begin
        if (exp_addr_q.size() == 0) check("unexpected_request", 1, 0);
        else check("memory_address", int'(bus.memory_address), int'(exp_addr_q.pop_front()));
      end else begin
        check("address_idle_zero", int'(bus.memory_address), 0);
      end
      if (bus.write_data_array) begin
        if (exp_wr_q.size() == 0) check("unexpected_data_write", 1, 0);
        else check("data_write", int'({bus.word_offset, bus.fill_data}), int'(exp_wr_q.pop_front()));
      end
      if (bus.write_tag_array) begin
        check("tag_with_data_write", int'(bus.write_data_array), 1);
        if (exp_tag_q.size() == 0) check("unexpected_tag_write", 1, 0);
        else check("tag_offset", int'(bus.word_offset), int'(exp_tag_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_busy"},   int'(bus.fsm_busy), 0);
    check({tag, "_mem_en"}, int'(bus.mem_en), 0);
    check({tag, "_addr"},   int'(bus.memory_address), 0);
    check({tag, "_wr"},     int'(bus.write_data_array), 0);
    check({tag, "_tag"},    int'(bus.write_tag_array), 0);
    check({tag, "_off"},    int'(bus.word_offset), 0);
    check({tag, "_data"},   int'(bus.fill_data), 0);
    check({tag, "_state"},  int'(bus.state_dbg), 0);
  endtask

  task automatic push_expect(input logic [15:0] base, input int n_req, input int n_wr, input bit tag);
    logic [15:0] a;
    for (int k = 0; k < n_req; k++) exp_addr_q.push_back(base + 16'(2 * k));
    for (int k = 0; k < n_wr; k++) begin
      a = base + 16'(2 * k);
      exp_wr_q.push_back({3'(k), a ^ 16'h5A5A});
    end
    if (tag) exp_tag_q.push_back(3'd7);
  endtask

  // miss cycle is c=0; tag expected at c=8+l, busy for 9+l cycles
  task automatic run_fill(input logic [15:0] addr, input int l, input bit toggle);
    int busy_n;
    int tag_c;
    lat = l;
    push_expect(addr & 16'hFFF0, 8, 8, 1'b1);
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    busy_n = 0;
    tag_c  = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.fsm_busy) busy_n++;
      if (bus.write_tag_array) begin
        tag_c = c;
        break;
      end
      cyc();
      if (toggle) begin
        bus.miss_detected = (c % 2 == 0);
        bus.miss_address  = 16'h7770;
      end else begin
        bus.miss_detected = 1'b0;
      end
    end
    cyc();
    bus.miss_detected = 1'b0;
    check("tag_latency", tag_c, 8 + l);
    check("busy_cycles", busy_n, 9 + l);
  endtask

  initial begin
    rst = 1'b1;
    bus.miss_detected = 1'b0;
    bus.miss_address  = '0;
    inj_valid = 1'b0;
    inj_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");
    mon_en = 1;

    // L=4 fill of a mid-block address
    cyc();
    run_fill(16'h1236, 4, 1'b0);

    // zero-latency memory, then confirm IDLE the following cycle
    run_fill(16'h0040, 0, 1'b0);
    check_idle("after_l0");

    // back-to-back misses
    cyc();
    run_fill(16'h2000, 2, 1'b0);
    run_fill(16'h3008, 2, 1'b0);

    // reset during the third returned word (cycle 7 after the miss at L=4)
    cyc();
    lat = 4;
    push_expect(16'h0500, 7, 3, 1'b0);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h0504;
    cyc();
    bus.miss_detected = 1'b0;
    repeat (6) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_idle("after_rst");
    repeat (3) cyc();
    run_fill(16'h0504, 4, 1'b0);

    // stray valids in IDLE, then miss toggling during a fill
    inj_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      inj_valid = 1'b1;
      @(negedge clk);
      check("idle_valid_no_write", int'(bus.write_data_array), 0);
      check("idle_valid_no_tag", int'(bus.write_tag_array), 0);
      cyc();
    end
    inj_valid = 1'b0;
    inj_data  = '0;
    run_fill(16'h0A12, 2, 1'b1);

    // top-of-memory block must not wrap
    cyc();
    run_fill(16'hFFFE, 3, 1'b0);

    repeat (4) cyc();
    check("addr_queue_empty", exp_addr_q.size(), 0);
    check("data_queue_empty", exp_wr_q.size(), 0);
    check("tag_queue_empty", exp_tag_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
